// File: rtl/axi_pkg.sv
// axi_pkg
//   Shared AXI4 encodings for the write master and the DDR slave wrapper:
//   response codes, burst type, default cache attribute, the AW-size
//   encoding helper, and the write-master FSM state type (exposed on the
//   master's fsm_state debug port).
package axi_pkg;

    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;
    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_t;

    // AxSIZE encoding: log2 of the bytes per beat. Falls back to 0 for
    // widths that are not a power of two.
    function automatic logic [2:0] axi_size(input int unsigned bpb);
        logic [2:0] enc;
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bpb) enc = 3'(i);
        end
        return enc;
    endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// axi_burst_len_calc
//   Combinational burst sizing: the number of beats for the next burst is the
//   smallest of the beats still to send, the MAX_BURST cap, and the beats
//   left before the next 4 KB boundary.
//   Ports:
//     remaining    in  16  beats still owed for the current command
//     page_offset  in  12  byte offset of the burst start within its 4 KB page
//     len          out  9  beats for this burst (1..MAX_BURST when remaining > 0)
module axi_burst_len_calc #(
    parameter int BPB       = 16,
    parameter int MAX_BURST = 16
) (
    input  logic [15:0] remaining,
    input  logic [11:0] page_offset,
    output logic [8:0]  len
);

    localparam int SHIFT = $clog2(BPB);

    logic [12:0] page_bytes;
    logic [12:0] page_beats;
    logic [15:0] cap;

    always_comb begin
        page_bytes = 13'd4096 - {1'b0, page_offset};
        page_beats = page_bytes >> SHIFT;
        cap        = (remaining < 16'(MAX_BURST)) ? remaining : 16'(MAX_BURST);
        if ({3'b000, page_beats} < cap) cap = {3'b000, page_beats};
        len        = cap[8:0];
    end

endmodule

// File: rtl/axi_stream_wr_master.sv
// axi_stream_wr_master
//   Turns a (start address, beat count) command plus a valid/ready data stream
//   into AXI4 INCR write bursts, one burst outstanding at a time. Bursts are
//   capped at MAX_BURST beats and never cross a 4 KB boundary.
//   Ports:
//     aclk, aresetn            clock, asynchronous active-low reset
//     cmd_valid/ready          command handshake; cmd_addr (low bits forced 0), cmd_beats
//     s_tdata/tvalid/tready    input stream, passed straight through to W
//     done                     one-cycle pulse when a command completes
//     err                      sticky non-OKAY response flag, cleared on command accept
//     aw*, w*, b*              AXI4 write address, data and response channels
//     fsm_state                current FSM state for observation
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. Once a valid is raised it holds, with its payload stable, until
//   the transfer. wvalid follows s_tvalid and s_tready follows wready, so each
//   ready/valid only depends on the partner's signal of the other direction,
//   never on its own output, which avoids any valid->ready loop.
module axi_stream_wr_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int AXI_ID     = 0,
    parameter int MAX_BURST  = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [15:0]             cmd_beats,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic                    done,
    output logic                    err,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic [3:0]              awqos,
    output logic [3:0]              awregion,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output wr_state_t               fsm_state
);

    localparam int BPB   = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BPB);
    localparam logic [2:0] AWSIZE = axi_size(BPB);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPB - 1);

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           rem_q;
    logic [7:0]            awlen_q;
    logic                  awvalid_q;
    logic [7:0]            beat_q;
    logic                  done_q;
    logic                  err_q;
    logic                  live_q;      // low while in reset and for the edge that releases it

    logic                  cmd_hs, aw_hs, w_hs, b_hs;
    logic [8:0]            len_cur;
    logic [ADDR_WIDTH-1:0] burst_bytes;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [15:0]           next_rem;
    logic [15:0]           calc_rem;
    logic [11:0]           calc_off;
    logic [8:0]            calc_len;

    // Length of the burst in flight and the position/count after it.
    assign len_cur     = {1'b0, awlen_q} + 9'd1;
    assign burst_bytes = ADDR_WIDTH'(len_cur) << SHIFT;
    assign next_addr   = addr_q + burst_bytes;
    assign next_rem    = rem_q - {7'b0, len_cur};

    // In RESP the next burst is sized from the post-burst position so that
    // awvalid can rise in the cycle right after the B handshake. Elsewhere
    // (first cycle of ADDR after a command) the latched values are used.
    assign calc_rem = (state_q == RESP) ? next_rem : rem_q;
    assign calc_off = (state_q == RESP) ? next_addr[11:0] : addr_q[11:0];

    axi_burst_len_calc #(
        .BPB       (BPB),
        .MAX_BURST (MAX_BURST)
    ) u_len_calc (
        .remaining   (calc_rem),
        .page_offset (calc_off),
        .len         (calc_len)
    );

    assign cmd_ready = (state_q == IDLE) && live_q;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign aw_hs     = awvalid_q && awready;
    assign w_hs      = (state_q == DATA) && s_tvalid && wready;
    assign b_hs      = (state_q == RESP) && bvalid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_hs && (cmd_beats != 16'd0)) state_d = ADDR;
            ADDR:    if (aw_hs) state_d = DATA;
            DATA:    if (w_hs && wlast) state_d = RESP;
            RESP:    if (b_hs) state_d = (next_rem == 16'd0) ? IDLE : ADDR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            beat_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        addr_q <= cmd_addr & ALIGN_MASK;
                        rem_q  <= cmd_beats;
                        err_q  <= 1'b0;
                        done_q <= (cmd_beats == 16'd0);
                    end
                end
                ADDR: begin
                    if (!awvalid_q) begin
                        awlen_q   <= 8'(calc_len - 9'd1);
                        awvalid_q <= 1'b1;
                    end else if (awready) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                    end
                end
                DATA: begin
                    if (w_hs) beat_q <= beat_q + 8'd1;
                end
                RESP: begin
                    if (b_hs) begin
                        if (bresp != RESP_OKAY) err_q <= 1'b1;
                        addr_q <= next_addr;
                        rem_q  <= next_rem;
                        if (next_rem == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            awlen_q   <= 8'(calc_len - 9'd1);
                            awvalid_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign awid     = ID_WIDTH'(AXI_ID);
    assign awaddr   = addr_q;
    assign awlen    = awlen_q;
    assign awsize   = AWSIZE;
    assign awburst  = BURST_INCR;
    assign awlock   = 1'b0;
    assign awcache  = CACHE_DEFAULT;
    assign awprot   = 3'b000;
    assign awqos    = 4'b0000;
    assign awregion = 4'b0000;
    assign awvalid  = awvalid_q;

    assign wdata    = s_tdata;
    assign wstrb    = '1;
    assign wvalid   = (state_q == DATA) && s_tvalid;
    assign s_tready = (state_q == DATA) && wready;
    assign wlast    = (state_q == DATA) && (beat_q == awlen_q);

    assign bready   = (state_q == RESP);
    assign done     = done_q;
    assign err      = err_q;
    assign fsm_state = state_q;

    // Single outstanding burst, so the response ID carries no information.
    logic unused_bid;
    assign unused_bid = ^bid;

endmodule

// File: doc/axi_stream_wr_master.md
# axi_stream_wr_master

Upstream AXI4 write master that feeds the DDR slave wrapper's write channel. It accepts a command (start address, beat count), moves a valid/ready data stream into AXI4 INCR bursts, and waits for each write response. Bursts are capped at MAX_BURST beats and never cross a 4 KB boundary. Only one burst is outstanding at a time, which matches the single-burst write FSM of the DDR slave.

## Interface
- DATA_WIDTH, 128, AXI data width in bits; BPB = DATA_WIDTH/8 bytes per beat
- ADDR_WIDTH, 32, AXI address width
- ID_WIDTH, 8, AXI ID width
- AXI_ID, 0, constant driven on awid
- MAX_BURST, 16, maximum beats per burst (1..256)
- aclk  in  1  single clock, all logic rising-edge
- aresetn  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(BPB) bits ignored (forced 0)
- cmd_beats  in  16  total beats to write
- s_tdata  in  DATA_WIDTH  stream payload
- s_tvalid / s_tready  in/out  1  stream handshake
- done  out  1  one-cycle pulse when a command completes
- err  out  1  sticky; set on any bresp != OKAY, cleared by cmd acceptance
- awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid / awready  out/in  AXI AW channel
- awlock=0, awcache=4'b0011, awprot=0, awqos=0, awregion=0  out  constants
- wdata, wstrb (all ones), wlast, wvalid / wready  out/in  AXI W channel
- bid, bresp[1:0], bvalid / bready  in/out  AXI B channel; bid ignored

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch addr (aligned), remaining=cmd_beats, clear err. If cmd_beats==0, pulse done the next cycle and stay in IDLE. Otherwise go to ADDR.
- Burst length len = min(remaining, MAX_BURST, (4096 - addr[11:0]) / BPB). The value is registered on entry to ADDR. awlen = len-1. awsize = log2(BPB). awburst = INCR.
- ADDR: awvalid=1 and awaddr/awlen stable until awready. On handshake go to DATA, with beat counter = 0.
- DATA: wvalid = s_tvalid, s_tready = wready, wdata = s_tdata. No buffering; combinational pass-through. On each w handshake the beat counter increments. wlast=1 when counter == awlen. The handshake with wlast moves the FSM to RESP.
- RESP: bready=1. On bvalid: if bresp != 2'b00, set err. Then update remaining -= len and addr += len*BPB.
  - If remaining == 0: pulse done, go to IDLE.
  - Otherwise: go to ADDR.
- s_tready=0 outside DATA. awvalid=0 outside ADDR. wvalid=0 outside DATA.
- addr arithmetic is modulo 2^ADDR_WIDTH. remaining never underflows because len ≤ remaining.
- Reset mid-operation: all state is discarded immediately, the FSM returns to IDLE, and the AXI valids drop asynchronously.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after; awvalid=0, wvalid=0, wlast=0, bready=0, s_tready=0, done=0, err=0, awaddr=0, awlen=0.
- Command accept → awvalid: 2 cycles (IDLE→ADDR edge, len registered in ADDR).
- AW handshake → first wvalid possible: 1 cycle.
- B handshake → next awvalid: 1 cycle (RESP→ADDR).
- B handshake on the final burst → done high in the next cycle, and cmd_ready=1 in that same cycle.
- Throughput is 1 beat/cycle within a burst when s_tvalid and wready are both held high.
- awvalid/awaddr/awlen are registered; wvalid/s_tready are combinational from the handshake partner, with no combinational loop on valid→ready.

## Structure
- Package axi_pkg holds the AXI4 constants (RESP_OKAY, BURST_INCR, CACHE_DEFAULT=4'b0011) and the size-encoding function log2(BPB). The DDR slave wrapper should import the same package.
- Single module. An optional sub-module axi_burst_len_calc (combinational min of remaining/MAX_BURST/4K-distance) keeps the FSM readable.

## Test plan
- Cmd addr=0x0, beats=4, slave always ready → one AW (awaddr=0x0, awlen=3, awsize=4). Four W beats, wlast on the 4th; done 1 cycle after B.
- Cmd addr=0x0, beats=40, MAX_BURST=16 → three bursts awlen=15,15,7 at awaddr 0x000, 0x100, 0x200.
- Cmd addr=0xFC0, beats=8 → 4K split: awlen=3 at 0xFC0, then awlen=3 at 0x1000.
- Cmd beats=0 → no AXI activity, done pulses in the cycle after acceptance.
- beats=16 with random s_tvalid/wready/awready/bvalid stalls → data order preserved, no beat dropped or duplicated, and wlast only on beat 16. With bresp=SLVERR on one burst → err=1 after done.
- aresetn deasserted in DATA after 3 of 8 beats → all valids 0 immediately, and a new cmd (addr 0x40, beats 2) then completes normally.
